// File: rtl/man_rx_kb_if.sv
// Line input and DSP-side word/status bundle of the KB Manchester receiver.
// With KB_SHADOW_EN defined the bundle also carries the shadow-buffer read port.
interface man_rx_kb_if;
  logic        i_man_rx;
  logic [15:0] o_word;
  logic [2:0]  o_word_idx;
  logic        o_word_valid;
  logic        o_frame_done;
  logic        o_frame_ok;
  logic        o_sum_err;
  logic        o_crc_err;
  logic        o_sync_err;
  logic [15:0] o_frame_cnt;
`ifdef KB_SHADOW_EN
  logic [2:0]  i_rd_addr;
  logic [15:0] o_rd_data;

  modport master (
    output i_man_rx, i_rd_addr,
    input  o_word, o_word_idx, o_word_valid, o_frame_done, o_frame_ok,
           o_sum_err, o_crc_err, o_sync_err, o_frame_cnt, o_rd_data
  );
  modport slave (
    input  i_man_rx, i_rd_addr,
    output o_word, o_word_idx, o_word_valid, o_frame_done, o_frame_ok,
           o_sum_err, o_crc_err, o_sync_err, o_frame_cnt, o_rd_data
  );
`else
  modport master (
    output i_man_rx,
    input  o_word, o_word_idx, o_word_valid, o_frame_done, o_frame_ok,
           o_sum_err, o_crc_err, o_sync_err, o_frame_cnt
  );
  modport slave (
    input  i_man_rx,
    output o_word, o_word_idx, o_word_valid, o_frame_done, o_frame_ok,
           o_sum_err, o_crc_err, o_sync_err, o_frame_cnt
  );
`endif
endinterface

// File: rtl/man_rx_kb.sv
// Manchester receiver for the KB link: bit recovery, header/checksum/CRC checks, word streaming.
// Optional macro KB_SHADOW_EN adds an 8x16 shadow buffer holding the last good frame.
module man_rx_kb #(
  parameter int          CLK_PER_BIT = 10,
  parameter logic [15:0] HEADER      = 16'h0564,
  parameter int          DATA_WORDS  = 8,
  parameter logic [15:0] CRC_POLY    = 16'h3D65,
  parameter int          TIMEOUT     = 15
) (
  input logic        i_sys_clk,
  input logic        reset,
  man_rx_kb_if.slave bus
);
  localparam int            CW        = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] HUNT_MIN  = CW'(CLK_PER_BIT - 2);
  localparam logic [CW-1:0] HUNT_MAX  = CW'(CLK_PER_BIT + 2);
  localparam logic [CW-1:0] LOCK_MIN  = CW'(CLK_PER_BIT - 3);
  localparam logic [CW-1:0] LOCK_MAX  = CW'(CLK_PER_BIT + 3);
  localparam logic [CW-1:0] CNT_LIMIT = CW'(TIMEOUT);
  localparam logic [2:0]    LAST_IDX  = 3'(DATA_WORDS - 1);

  typedef enum logic [2:0] {ST_HUNT, ST_HEADER, ST_DATA, ST_CRC, ST_DONE} state_t;

  state_t        state, state_nxt;
  logic          sync1, sync2, edge_q;
  logic [CW-1:0] cnt;
  logic [15:0]   shreg, crc, sum;
  logic [3:0]    bit_cnt;
  logic [2:0]    word_idx;
  logic          sum_bad, crc_bad;

  logic [15:0] word_q, frame_cnt_q;
  logic [2:0]  word_idx_q;
  logic        word_valid_q, frame_done_q, frame_ok_q, sum_err_q, crc_err_q, sync_err_q;

  logic        line_edge, bit_val, locked, hunt_hit, lock_hit, accept, timeout;
  logic        last_bit, word_done, frame_good, crc_t;
  logic [15:0] word_full, crc_next;

  // A mid-bit edge follows the previous accepted one by about one bit time;
  // HUNT uses a tighter window so that idle 1s (edges every half bit) never lock.
  assign line_edge  = sync2 ^ edge_q;
  assign bit_val    = sync2;
  assign locked     = (state == ST_HEADER) || (state == ST_DATA) || (state == ST_CRC);
  assign hunt_hit   = line_edge && (cnt >= HUNT_MIN) && (cnt <= HUNT_MAX);
  assign lock_hit   = line_edge && (cnt >= LOCK_MIN) && (cnt <= LOCK_MAX);
  assign accept     = (state == ST_HUNT) ? hunt_hit : (locked && lock_hit);
  assign timeout    = locked && (cnt == CNT_LIMIT);
  assign last_bit   = (bit_cnt == 4'd15);
  assign word_full  = {shreg[14:0], bit_val};
  assign word_done  = (state == ST_DATA) && accept && last_bit;
  assign frame_good = !sum_bad && !crc_bad;
  assign crc_t      = bit_val ^ crc[15];
  assign crc_next   = {crc[14:0], 1'b0} ^ (crc_t ? CRC_POLY : 16'h0000);

  always_ff @(posedge i_sys_clk or posedge reset) begin
    if (reset) state <= ST_HUNT;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_HUNT:   if (accept) state_nxt = ST_HEADER;
      ST_HEADER: if (timeout) state_nxt = ST_HUNT;
                 else if (accept && last_bit)
                   state_nxt = (word_full == HEADER) ? ST_DATA : ST_HUNT;
      ST_DATA:   if (timeout) state_nxt = ST_HUNT;
                 else if (word_done && (word_idx == LAST_IDX)) state_nxt = ST_CRC;
      ST_CRC:    if (timeout) state_nxt = ST_HUNT;
                 else if (accept && last_bit) state_nxt = ST_DONE;
      ST_DONE:   state_nxt = ST_HUNT;
      default:   state_nxt = ST_HUNT;
    endcase
  end

  // Line sampling, bit shifting, checksum/CRC accumulation and the output strobes.
  always_ff @(posedge i_sys_clk or posedge reset) begin
    if (reset) begin
      sync1        <= 1'b0;
      sync2        <= 1'b0;
      edge_q       <= 1'b0;
      cnt          <= '0;
      shreg        <= '0;
      bit_cnt      <= '0;
      word_idx     <= '0;
      crc          <= '0;
      sum          <= '0;
      sum_bad      <= 1'b0;
      crc_bad      <= 1'b0;
      word_q       <= '0;
      word_idx_q   <= '0;
      word_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
      frame_ok_q   <= 1'b0;
      sum_err_q    <= 1'b0;
      crc_err_q    <= 1'b0;
      sync_err_q   <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      sync1  <= bus.i_man_rx;
      sync2  <= sync1;
      edge_q <= sync2;

      if (accept || ((state == ST_HUNT) && line_edge)) cnt <= '0;
      else if (cnt != CNT_LIMIT)                       cnt <= cnt + 1'b1;

      word_valid_q <= 1'b0;
      frame_done_q <= 1'b0;

      if (accept) begin
        if (state == ST_HUNT) begin
          shreg   <= {15'h0000, bit_val};
          bit_cnt <= 4'd1;
        end else begin
          shreg   <= word_full;
          bit_cnt <= bit_cnt + 4'd1;
        end
      end

      if ((state == ST_HEADER) && accept && last_bit) begin
        crc      <= '0;
        sum      <= '0;
        word_idx <= '0;
        sum_bad  <= 1'b0;
        crc_bad  <= 1'b0;
      end

      if ((state == ST_DATA) && accept) crc <= crc_next;

      if (word_done) begin
        word_q       <= word_full;
        word_idx_q   <= word_idx;
        word_valid_q <= 1'b1;
        word_idx     <= word_idx + 3'd1;
        if (word_idx == LAST_IDX) sum_bad <= (word_full != ~sum);
        else                      sum     <= sum + word_full;
      end

      if ((state == ST_CRC) && accept && last_bit) crc_bad <= (word_full != ~crc);

      if (timeout) begin
        frame_done_q <= 1'b1;
        frame_ok_q   <= 1'b0;
        sum_err_q    <= 1'b0;
        crc_err_q    <= 1'b0;
        sync_err_q   <= 1'b1;
      end

      if (state == ST_DONE) begin
        frame_done_q <= 1'b1;
        frame_ok_q   <= frame_good;
        sum_err_q    <= sum_bad;
        crc_err_q    <= crc_bad;
        sync_err_q   <= 1'b0;
        if (frame_good) frame_cnt_q <= frame_cnt_q + 16'd1;
      end
    end
  end

  assign bus.o_word       = word_q;
  assign bus.o_word_idx   = word_idx_q;
  assign bus.o_word_valid = word_valid_q;
  assign bus.o_frame_done = frame_done_q;
  assign bus.o_frame_ok   = frame_ok_q;
  assign bus.o_sum_err    = sum_err_q;
  assign bus.o_crc_err    = crc_err_q;
  assign bus.o_sync_err   = sync_err_q;
  assign bus.o_frame_cnt  = frame_cnt_q;

`ifdef KB_SHADOW_EN
  logic [15:0] stage  [8];
  logic [15:0] shadow [8];
  logic [15:0] rd_data_q;

  // Staging collects the current frame; it is committed to the shadow only once the frame checks out.
  always_ff @(posedge i_sys_clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) begin
        stage[i]  <= '0;
        shadow[i] <= '0;
      end
      rd_data_q <= '0;
    end else begin
      if (word_done) stage[word_idx] <= word_full;
      if ((state == ST_DONE) && frame_good) begin
        for (int i = 0; i < 8; i++) shadow[i] <= stage[i];
      end
      rd_data_q <= shadow[bus.i_rd_addr];
    end
  end

  assign bus.o_rd_data = rd_data_q;
`endif
endmodule
